// File: rtl/sonar_pkg.sv
// +--------------------------------------------------------------------+
// | sonar_pkg: shared types and helpers for the sonar scheduler         |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package sonar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GUARD = 2'd3
  } state_e;

  localparam logic [7:0] DIST_TIMEOUT = 8'hFF;

  function automatic logic [31:0] ms_to_cyc(input int unsigned freq_hz, input int unsigned ms);
    return freq_hz / 32'd1000 * ms;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sonar_rr_next.sv
// +--------------------------------------------------------------------+
// | sonar_rr_next: finds the next enabled channel after ptr, or the     |
// | lowest enabled channel when restarting or wrapping.  Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module sonar_rr_next #(
  parameter int unsigned N_SONARS = 4,
  parameter int unsigned ID_W     = 2
) (
  input  logic [ID_W-1:0]     ptr,
  input  logic                restart,
  input  logic [N_SONARS-1:0] enable,
  output logic [ID_W-1:0]     next_idx,
  output logic                wrap,
  output logic                any_en
);

  logic [ID_W-1:0] first_idx;
  logic [ID_W-1:0] later_idx;
  logic            later_found;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    first_idx   = '0;
    later_idx   = '0;
    later_found = 1'b0;
    for (int i = N_SONARS - 1; i >= 0; i--) begin
      if (enable[i]) begin
        first_idx = ID_W'(i);
        if (!restart && (i > int'(ptr))) begin
          later_idx   = ID_W'(i);
          later_found = 1'b1;
        end
      end
    end
    wrap     = !later_found;
    next_idx = later_found ? later_idx : first_idx;
    any_en   = |enable;
  end

endmodule

`default_nettype wire

// File: rtl/sonar_scheduler.sv
// +--------------------------------------------------------------------+
// | sonar_scheduler: round-robin HC-SR04 measurement sequencer with     |
// | guard interval and timeout. Option macro: SONAR_SCHED_MASK_EN       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int unsigned N_SONARS   = 4,
  parameter int unsigned FREQ       = 50_000_000,
  parameter int unsigned GUARD_MS   = 60,
  parameter int unsigned TIMEOUT_MS = 40,
  localparam int unsigned ID_W      = (N_SONARS > 1) ? $clog2(N_SONARS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
`ifdef SONAR_SCHED_MASK_EN
  input  logic [N_SONARS-1:0]   chan_mask,
`endif
  output logic [N_SONARS-1:0]   drv_measure,
  input  logic [N_SONARS-1:0]   drv_ready,
  input  logic [8*N_SONARS-1:0] drv_distance,
  output logic                  busy,
  output logic                  result_valid,
  output logic [ID_W-1:0]       result_id,
  output logic [7:0]            result_dist,
  output logic                  result_timeout,
  output logic                  sweep_done
);

  localparam logic [31:0]         GUARD_CYC   = ms_to_cyc(FREQ, GUARD_MS);
  localparam logic [31:0]         TIMEOUT_CYC = ms_to_cyc(FREQ, TIMEOUT_MS);
  localparam logic [N_SONARS-1:0] ONE_HOT0    = N_SONARS'(1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [N_SONARS-1:0] en_q, en_d;
  logic [31:0]         tcnt_q, tcnt_d;
  logic [31:0]         gcnt_q, gcnt_d;
  logic                armed_q, armed_d;
  logic                busy_q, busy_d;
  logic [N_SONARS-1:0] drv_measure_q, drv_measure_d;
  logic                result_valid_q, result_valid_d;
  logic [ID_W-1:0]     result_id_q, result_id_d;
  logic [7:0]          result_dist_q, result_dist_d;
  logic                result_timeout_q, result_timeout_d;
  logic                sweep_done_q, sweep_done_d;

  logic [N_SONARS-1:0] en_live;
  logic                in_idle;
  logic [ID_W-1:0]     rr_idx;
  logic                rr_wrap;
  logic                rr_any;
  logic                ready_sel;
  logic [7:0]          dist_arr [N_SONARS];

`ifdef SONAR_SCHED_MASK_EN
  assign en_live = chan_mask;
`else
  assign en_live = '1;
`endif

  for (genvar k = 0; k < N_SONARS; k++) begin : g_dist
    assign dist_arr[k] = drv_distance[8*k +: 8];
  end

  assign in_idle   = (state_q == IDLE);
  assign ready_sel = drv_ready[ptr_q];

  // In IDLE the live mask is searched from channel 0; mid-sweep the held mask is used.
  sonar_rr_next #(
    .N_SONARS (N_SONARS),
    .ID_W     (ID_W)
  ) u_rr_next (
    .ptr      (ptr_q),
    .restart  (in_idle),
    .enable   (in_idle ? en_live : en_q),
    .next_idx (rr_idx),
    .wrap     (rr_wrap),
    .any_en   (rr_any)
  );

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    en_d             = en_q;
    tcnt_d           = tcnt_q;
    gcnt_d           = gcnt_q;
    armed_d          = armed_q;
    busy_d           = busy_q;
    drv_measure_d    = '0;
    result_valid_d   = 1'b0;
    result_id_d      = result_id_q;
    result_dist_d    = result_dist_q;
    result_timeout_d = result_timeout_q;
    sweep_done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((start || continuous) && rr_any) begin
          ptr_d         = rr_idx;
          en_d          = en_live;
          busy_d        = 1'b1;
          drv_measure_d = ONE_HOT0 << rr_idx;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_d  = TIMEOUT_CYC;
        armed_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        // Ready is stale-high from the previous run until it has been seen low.
        if (armed_q && ready_sel) begin
          result_valid_d   = 1'b1;
          result_id_d      = ptr_q;
          result_dist_d    = dist_arr[ptr_q];
          result_timeout_d = 1'b0;
          gcnt_d           = GUARD_CYC;
          state_d          = GUARD;
        end else begin
          armed_d = armed_q | ~ready_sel;
          if (tcnt_q <= 32'd1) begin
            result_valid_d   = 1'b1;
            result_id_d      = ptr_q;
            result_dist_d    = DIST_TIMEOUT;
            result_timeout_d = 1'b1;
            gcnt_d           = GUARD_CYC;
            state_d          = GUARD;
          end else begin
            tcnt_d = tcnt_q - 32'd1;
          end
        end
      end
      GUARD: begin
        if (gcnt_q > 32'd1) begin
          gcnt_d = gcnt_q - 32'd1;
        end else if (!rr_wrap) begin
          ptr_d         = rr_idx;
          drv_measure_d = ONE_HOT0 << rr_idx;
          state_d       = ISSUE;
        end else begin
          sweep_done_d = 1'b1;
          if (continuous) begin
            ptr_d         = rr_idx;
            drv_measure_d = ONE_HOT0 << rr_idx;
            state_d       = ISSUE;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      ptr_q            <= '0;
      en_q             <= '0;
      tcnt_q           <= '0;
      gcnt_q           <= '0;
      armed_q          <= 1'b0;
      busy_q           <= 1'b0;
      drv_measure_q    <= '0;
      result_valid_q   <= 1'b0;
      result_id_q      <= '0;
      result_dist_q    <= '0;
      result_timeout_q <= 1'b0;
      sweep_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      en_q             <= en_d;
      tcnt_q           <= tcnt_d;
      gcnt_q           <= gcnt_d;
      armed_q          <= armed_d;
      busy_q           <= busy_d;
      drv_measure_q    <= drv_measure_d;
      result_valid_q   <= result_valid_d;
      result_id_q      <= result_id_d;
      result_dist_q    <= result_dist_d;
      result_timeout_q <= result_timeout_d;
      sweep_done_q     <= sweep_done_d;
    end
  end

  assign drv_measure    = drv_measure_q;
  assign busy           = busy_q;
  assign result_valid   = result_valid_q;
  assign result_id      = result_id_q;
  assign result_dist    = result_dist_q;
  assign result_timeout = result_timeout_q;
  assign sweep_done     = sweep_done_q;

endmodule

`default_nettype wire
